dec_unbinder_probe: RTL and testbench
=====================================

# dec_unbinder_probe

Sequential decoder-side counterpart of the encoder binders. It takes one bound hypervector and the permutation shift of a single feature, and undoes the binding by rotating the vector in the opposite direction. It then scans the level item memory and reports which level hypervector best matches the unbound vector, using sparse overlap (popcount of bitwise AND). It sits after the encoder in feature-recovery and debug paths and reads the same level memory that feeds the binders.

## Interface
Parameters:
- HV_DIM, 1024 — hypervector width in bits. Must be a power of two.
- NUM_LEVELS, 16 — number of level hypervectors in the item memory. Minimum 2.
- LVL_W, $clog2(NUM_LEVELS) — level index width.
- SHIFT_W, $clog2(HV_DIM) — shift amount width.
- SCORE_W, $clog2(HV_DIM+1) — overlap score width.

Ports:
- clk  input  1  — single clock; all state updates on the rising edge.
- nrst  input  1  — asynchronous, active-low reset.
- start_decoding  input  1  — request; sampled only in IDLE.
- bound_hv  input  HV_DIM  — bound vector; sampled with start_decoding.
- shift_amt  input  SHIFT_W  — feature shift, equal to the SHIFT used by the encoder for that feature; sampled with start_decoding.
- level_rd_en  output  1  — item-memory read strobe.
- level_addr  output  LVL_W  — item-memory read address.
- level_rd_data  input  HV_DIM  — read data; valid exactly 1 cycle after level_rd_en.
- busy  output  1  — high from the cycle after start is accepted until done.
- done  output  1  — one-cycle pulse; result valid.
- best_level  output  LVL_W  — index of the best-matching level.
- best_score  output  SCORE_W  — overlap count of best_level.

## Operation
- Encoder convention: shifted[(j+SHIFT) mod HV_DIM] = level[j], i.e. rotate-left. This block computes unbound[j] = bound_hv[(j+shift_amt) mod HV_DIM] (rotate-right) and registers the result in unbound_q.
- shift_amt is naturally reduced modulo HV_DIM by its width. A shift of 0 means identity.
- FSM states:
  - IDLE: busy=0. If start_decoding=1, register unbound_q, clear the address counter to 0, clear the running best (score 0, level 0), and go to SCAN.
  - SCAN: level_rd_en=1 and level_addr=k, with k incrementing each cycle. After issuing k=NUM_LEVELS-1, go to DRAIN.
  - DRAIN: level_rd_en=0. Waits one cycle for the last read data, then goes to DONE.
  - DONE: done=1 for one cycle, then return to IDLE.
- Compare pipeline:
  - A registered valid/index pair follows each read by one cycle.
  - When valid, score = popcount(unbound_q & level_rd_data).
  - If score > running best_score (strictly greater), update best_score and best_level.
  - Ties keep the lower index. All-zero overlap yields level 0, score 0.
- Popcount is a full-width adder tree, combinational within one cycle. Its width is SCORE_W and it cannot overflow.
- best_level and best_score are visible while scanning (running values). They are final when done=1 and are held until the next accepted start.
- start_decoding outside IDLE is ignored. bound_hv and shift_amt changes after acceptance have no effect.

## Timing
- Start sampled at edge T (state IDLE). SCAN covers cycles T+1 .. T+NUM_LEVELS, with address k issued in cycle T+1+k.
- Data for k arrives in cycle T+2+k and is compared at the edge ending that cycle.
- DRAIN is cycle T+NUM_LEVELS+1, which compares the last level.
- done=1 in cycle T+NUM_LEVELS+2. Start-to-done latency is NUM_LEVELS+2 cycles.
- busy=1 for cycles T+1 .. T+NUM_LEVELS+1; busy=0 in the done cycle.
- Earliest back-to-back start is sampled in the cycle after done, when the FSM is back in IDLE. A start asserted during the done cycle is ignored.
- Reset (nrst=0, any time, asynchronous):
  - State goes to IDLE.
  - busy, done, level_rd_en, level_addr, best_level and best_score all become 0; unbound_q is cleared.
  - An in-flight scan is aborted with no done pulse.
  - Normal operation resumes on the first edge after nrst deasserts.

## Test plan
All scenarios use HV_DIM=16, NUM_LEVELS=4, with levels L0=16'h0003, L1=16'h00F0, L2=16'h0F00, L3=16'hF000.
- Basic decode: bound_hv=16'h0F00, shift_amt=4 -> unbound 16'h00F0; done exactly 6 cycles after start; best_level=1, best_score=4.
- Zero shift and wrap-around: bound_hv=16'h0003, shift_amt=0 -> best_level=0, score=2. Then bound_hv=16'h3000, shift_amt=12 -> unbound 16'h0003 (bits wrap) -> best_level=0, score=2.
- Tie and zero overlap:
  - bound_hv=16'h0FF0, shift_amt=0 -> L1 and L2 both score 4 -> best_level=1.
  - bound_hv=16'h0000 -> best_level=0, score=0.
- Read protocol: check level_addr sequence 0,1,2,3 in consecutive cycles with level_rd_en high exactly 4 cycles. A start pulsed mid-scan is ignored, with no second scan.
- Reset mid-scan: drop nrst during SCAN k=2 -> all outputs 0 immediately and no done. A new start after release gives the correct result.
- Back-to-back: a second start in the cycle after done is accepted, and its result replaces the first.

Source files
------------

// File: rtl/dec_unbinder_probe.sv
`default_nettype none
// ============================================================================
// Module   : dec_unbinder_probe
// Purpose  : Undoes a single-feature permutation binding by rotating the bound
//            hypervector right by the feature shift. It then scans the level
//            item memory and reports the level with the largest sparse overlap,
//            where overlap is popcount(unbound & level).
// Revision : 1.0 - initial release
// ============================================================================
module dec_unbinder_probe #(
    parameter int HV_DIM     = 1024,
    parameter int NUM_LEVELS = 16,
    parameter int LVL_W      = $clog2(NUM_LEVELS),
    parameter int SHIFT_W    = $clog2(HV_DIM),
    parameter int SCORE_W    = $clog2(HV_DIM + 1)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               start_decoding,
    input  logic [HV_DIM-1:0]  bound_hv,
    input  logic [SHIFT_W-1:0] shift_amt,
    output logic               level_rd_en,
    output logic [LVL_W-1:0]   level_addr,
    input  logic [HV_DIM-1:0]  level_rd_data,
    output logic               busy,
    output logic               done,
    output logic [LVL_W-1:0]   best_level,
    output logic [SCORE_W-1:0] best_score
);

    localparam logic [LVL_W-1:0] C_LAST_ADDR = LVL_W'(NUM_LEVELS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [HV_DIM-1:0]    r_unbound;
    logic [LVL_W-1:0]     r_addr;
    logic                 r_rd_en;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_vld;
    logic [LVL_W-1:0]     r_idx;
    logic [LVL_W-1:0]     r_best_level;
    logic [SCORE_W-1:0]   r_best_score;

    logic [2*HV_DIM-1:0]  w_dbl;
    logic [2*HV_DIM-1:0]  w_rot;
    logic [HV_DIM-1:0]    w_unbound;
    logic [HV_DIM-1:0]    w_and;
    logic [SCORE_W-1:0]   w_score;
    logic                 w_accept;

    // Rotate right: unbound[j] = bound[(j+shift) mod HV_DIM], via a doubled vector.
    assign w_dbl     = {bound_hv, bound_hv};
    assign w_rot     = w_dbl >> shift_amt;
    assign w_unbound = w_rot[HV_DIM-1:0];

    assign w_accept  = (r_state == S_IDLE) && start_decoding;
    assign w_and     = r_unbound & level_rd_data;

    // Full-width popcount of the overlap; SCORE_W can hold HV_DIM so it never wraps.
    always_comb begin
        w_score = '0;
        for (int i = 0; i < HV_DIM; i++) begin
            w_score = w_score + SCORE_W'(w_and[i]);
        end
    end

    // Control FSM: accept, issue one read per level, drain the last read, pulse done.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= S_IDLE;
            r_unbound <= '0;
            r_addr    <= '0;
            r_rd_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_decoding) begin
                        r_unbound <= w_unbound;
                        r_addr    <= '0;
                        r_rd_en   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (r_addr == C_LAST_ADDR) begin
                        r_rd_en <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Compare stage: the valid/index pair trails each read by one cycle, strict > keeps lower index on ties.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_vld        <= 1'b0;
            r_idx        <= '0;
            r_best_level <= '0;
            r_best_score <= '0;
        end else begin
            r_vld <= r_rd_en;
            r_idx <= r_addr;
            if (w_accept) begin
                r_best_level <= '0;
                r_best_score <= '0;
            end else if (r_vld && (w_score > r_best_score)) begin
                r_best_level <= r_idx;
                r_best_score <= w_score;
            end
        end
    end

    assign level_rd_en = r_rd_en;
    assign level_addr  = r_addr;
    assign busy        = r_busy;
    assign done        = r_done;
    assign best_level  = r_best_level;
    assign best_score  = r_best_score;

endmodule
`default_nettype wire

// File: tb/tb_dec_unbinder_probe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_unbinder_probe
// Purpose  : Self-checking bench for dec_unbinder_probe with HV_DIM=16 and
//            NUM_LEVELS=4. Directed steps first, then randomized decodes
//            checked against a reference model of unbinding and best-overlap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dec_unbinder_probe;

    localparam int HV = 16;
    localparam int NL = 4;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bound = '0;
    logic [3:0]  shift = '0;
    logic        rd_en;
    logic [1:0]  addr;
    logic [15:0] rd_data = '0;
    logic        busy;
    logic        done;
    logic [1:0]  best_level;
    logic [4:0]  best_score;

    logic [15:0] lvl_mem [0:NL-1];

    int n_cmp  = 0;
    int n_fail = 0;

    dec_unbinder_probe #(
        .HV_DIM     (HV),
        .NUM_LEVELS (NL)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .start_decoding (start),
        .bound_hv       (bound),
        .shift_amt      (shift),
        .level_rd_en    (rd_en),
        .level_addr     (addr),
        .level_rd_data  (rd_data),
        .busy           (busy),
        .done           (done),
        .best_level     (best_level),
        .best_score     (best_score)
    );

    always #5 clk = ~clk;

    // Item memory model: data valid one cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en) rd_data <= lvl_mem[addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: unbind by the inverse of the encoder's rotate-left, then pick the first maximum overlap.
    function automatic void ref_decode(input logic [15:0] b, input int s, output int lvl, output int sc);
        logic [15:0] u;
        int c;
        for (int j = 0; j < HV; j++) u[j] = b[(j + s) % HV];
        lvl = 0;
        sc  = 0;
        for (int l = 0; l < NL; l++) begin
            c = $countones(u & lvl_mem[l]);
            if (c > sc) begin
                sc  = c;
                lvl = l;
            end
        end
    endfunction

    // Encoder convention: shifted[(j+s) mod HV] = level[j].
    function automatic logic [15:0] bind_rotl(input logic [15:0] v, input int s);
        logic [15:0] r;
        for (int j = 0; j < HV; j++) r[(j + s) % HV] = v[j];
        return r;
    endfunction

    task automatic set_directed_levels();
        lvl_mem[0] = 16'h0003;
        lvl_mem[1] = 16'h00F0;
        lvl_mem[2] = 16'h0F00;
        lvl_mem[3] = 16'hF000;
    endtask

    // Called at a negedge with the FSM idle; returns at the negedge of the cycle after done.
    task automatic run_decode(input string tag, input logic [15:0] b, input logic [3:0] s,
                              input bit mid_start, input bit done_start);
        int exp_lvl, exp_sc, k, n_rd, lat;
        ref_decode(b, int'(s), exp_lvl, exp_sc);
        start = 1'b1;
        bound = b;
        shift = s;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        bound = 16'($urandom);
        shift = 4'($urandom);
        k = 1;
        n_rd = 0;
        lat = 0;
        while (lat == 0 && k <= 20) begin
            if (done) begin
                lat = k;
            end else begin
                check({tag, "/busy"}, 32'(busy), 32'(k <= NL + 1));
                if (rd_en) begin
                    check({tag, "/addr"}, 32'(addr), 32'(n_rd));
                    n_rd++;
                end
                start = (mid_start && k == 2);
                if (start) bound = ~b;
                @(negedge clk);
                k++;
            end
        end
        check({tag, "/latency"}, 32'(lat), 32'(NL + 2));
        check({tag, "/reads"}, 32'(n_rd), 32'(NL));
        check({tag, "/busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "/level"}, 32'(best_level), 32'(exp_lvl));
        check({tag, "/score"}, 32'(best_score), 32'(exp_sc));
        start = done_start;
        @(negedge clk);
        start = 1'b0;
        check({tag, "/done_pulse"}, 32'(done), 32'd0);
        check({tag, "/level_held"}, 32'(best_level), 32'(exp_lvl));
        check({tag, "/score_held"}, 32'(best_score), 32'(exp_sc));
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check({tag, "/no_rd"}, 32'(rd_en), 32'd0);
            check({tag, "/no_busy"}, 32'(busy), 32'd0);
            check({tag, "/no_done"}, 32'(done), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/busy"}, 32'(busy), 32'd0);
        check({tag, "/done"}, 32'(done), 32'd0);
        check({tag, "/rd_en"}, 32'(rd_en), 32'd0);
        check({tag, "/addr"}, 32'(addr), 32'd0);
        check({tag, "/level"}, 32'(best_level), 32'd0);
        check({tag, "/score"}, 32'(best_score), 32'd0);
    endtask

    initial begin
        logic [15:0] b;
        logic [3:0]  s;
        set_directed_levels();

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        nrst = 1'b1;
        @(negedge clk);

        // Basic decode, zero shift, wrap-around
        run_decode("basic", 16'h0F00, 4'd4, 1'b0, 1'b0);
        run_decode("zero_shift", 16'h0003, 4'd0, 1'b0, 1'b0);
        run_decode("wrap", 16'h3000, 4'd12, 1'b0, 1'b0);

        // Tie keeps lower index; zero overlap gives level 0 score 0
        run_decode("tie", 16'h0FF0, 4'd0, 1'b0, 1'b0);
        run_decode("zero", 16'h0000, 4'd5, 1'b0, 1'b0);

        // Start pulsed mid-scan is ignored, no second scan follows
        run_decode("mid_start", 16'h00F0, 4'd0, 1'b1, 1'b0);
        check_quiet("after_mid", 6);

        // Start held only during the done cycle is ignored
        run_decode("done_start", 16'hF000, 4'd0, 1'b0, 1'b1);
        check_quiet("after_done_start", 4);

        // Reset during SCAN with address 2 issued
        start = 1'b1;
        bound = 16'h0003;
        shift = 4'd0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst/addr", 32'(addr), 32'd2);
        check("pre_rst/running_score", 32'(best_score), 32'd2);
        nrst = 1'b0;
        #1;
        check_all_zero("mid_rst");
        check_quiet("in_rst", 4);
        nrst = 1'b1;
        check_quiet("post_rst", 3);
        run_decode("after_rst", 16'h0F00, 4'd4, 1'b0, 1'b0);

        // Back-to-back: the second start lands in the cycle after done
        run_decode("b2b_first", 16'h00F0, 4'd0, 1'b0, 1'b0);
        run_decode("b2b_second", 16'h000F, 4'd4, 1'b0, 1'b0);

        // Randomized decodes with random item memories
        for (int it = 0; it < 24; it++) begin
            if (it % 4 == 0) begin
                for (int l = 0; l < NL; l++) lvl_mem[l] = 16'($urandom);
            end
            s = 4'($urandom);
            if ($urandom_range(1) == 1)
                b = bind_rotl(lvl_mem[$urandom_range(NL - 1)], int'(s));
            else
                b = 16'($urandom);
            run_decode("rand", b, s, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
